// File: rtl/lcd_readback.sv
// HD44780 DDRAM readback: polls the busy flag, sets the DDRAM address per line and
// reads both 16-character lines, one strobe per character.
module lcd_readback #(
    parameter int SETUP_CYC   = 3,
    parameter int EN_HIGH_CYC = 25,
    parameter int EN_LOW_CYC  = 25,
    parameter int POLL_MAX    = 4095
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iStart,
    inout  wire  [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic       oBusy,
    output logic [7:0] oChar,
    output logic [4:0] oCharAddr,
    output logic       oCharValid,
    output logic [6:0] oAC,
    output logic       oDone,
    output logic       oTimeout
);
    localparam int BUS_CYC = SETUP_CYC + EN_HIGH_CYC + EN_LOW_CYC;
    localparam int CW      = $clog2(BUS_CYC);
    localparam int PW      = $clog2(POLL_MAX + 1);

    localparam logic [CW-1:0] EN_ON  = CW'(SETUP_CYC);
    localparam logic [CW-1:0] EN_OFF = CW'(SETUP_CYC + EN_HIGH_CYC);
    localparam logic [CW-1:0] SAMPLE = CW'(SETUP_CYC + EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] LAST   = CW'(BUS_CYC - 1);

    typedef enum logic [2:0] {IDLE, POLL, SETADDR, READ, NEXT, DONE, TOUT} state_t;

    state_t          state, ret;
    logic [CW-1:0]   cyc;
    logic [PW-1:0]   poll_cnt;
    logic            line;
    logic [3:0]      chr;
    logic [7:0]      rd_byte;
    logic [7:0]      wr_byte;
    logic            in_bus;
    logic [CW-1:0]   cyc_nxt;

    assign in_bus   = (state == POLL) || (state == SETADDR) || (state == READ);
    assign cyc_nxt  = cyc + CW'(1);
    // Only the address-set write ever drives the bus; RW is 0 throughout that state.
    assign LCD_DATA = (state == SETADDR) ? wr_byte : 8'hzz;

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state      <= IDLE;
            ret        <= SETADDR;
            cyc        <= '0;
            poll_cnt   <= '0;
            line       <= 1'b0;
            chr        <= 4'd0;
            rd_byte    <= 8'h00;
            wr_byte    <= 8'h00;
            LCD_EN     <= 1'b0;
            LCD_RW     <= 1'b0;
            LCD_RS     <= 1'b0;
            oBusy      <= 1'b0;
            oChar      <= 8'h00;
            oCharAddr  <= 5'd0;
            oCharValid <= 1'b0;
            oAC        <= 7'd0;
            oDone      <= 1'b0;
            oTimeout   <= 1'b0;
        end else begin
            oCharValid <= 1'b0;
            oDone      <= 1'b0;
            oTimeout   <= 1'b0;
            if (in_bus && cyc != LAST) begin
                cyc    <= cyc_nxt;
                LCD_EN <= (cyc_nxt >= EN_ON) && (cyc_nxt < EN_OFF);
                if (cyc == SAMPLE && LCD_RW) begin
                    rd_byte <= LCD_DATA;
                    if (state == POLL)
                        oAC <= LCD_DATA[6:0];
                end
            end else begin
                // Bus-cycle completion (or a non-bus state): every new bus cycle restarts at cyc 0.
                cyc    <= '0;
                LCD_EN <= 1'b0;
                case (state)
                    IDLE: if (iStart) begin
                        oBusy    <= 1'b1;
                        line     <= 1'b0;
                        ret      <= SETADDR;
                        poll_cnt <= '0;
                        state    <= POLL;
                        LCD_RS   <= 1'b0;
                        LCD_RW   <= 1'b1;
                    end
                    POLL: if (!rd_byte[7]) begin
                        poll_cnt <= '0;
                        state    <= ret;
                        if (ret == SETADDR) begin
                            LCD_RS  <= 1'b0;
                            LCD_RW  <= 1'b0;
                            wr_byte <= line ? 8'hC0 : 8'h80;
                        end else begin
                            LCD_RS <= 1'b1;
                            LCD_RW <= 1'b1;
                        end
                    end else if (poll_cnt == PW'(POLL_MAX)) begin
                        state    <= TOUT;
                        oTimeout <= 1'b1;
                        oBusy    <= 1'b0;
                        LCD_RS   <= 1'b0;
                        LCD_RW   <= 1'b0;
                    end else begin
                        poll_cnt <= poll_cnt + PW'(1);
                    end
                    SETADDR: begin
                        state  <= POLL;
                        ret    <= READ;
                        chr    <= 4'd0;
                        LCD_RS <= 1'b0;
                        LCD_RW <= 1'b1;
                    end
                    READ: begin
                        oChar      <= rd_byte;
                        oCharAddr  <= {line, chr};
                        oCharValid <= 1'b1;
                        LCD_RS     <= 1'b0;
                        if (chr != 4'd15) begin
                            chr    <= chr + 4'd1;
                            state  <= POLL;
                            ret    <= READ;
                            LCD_RW <= 1'b1;
                        end else begin
                            state  <= NEXT;
                            LCD_RW <= 1'b0;
                        end
                    end
                    NEXT: if (!line) begin
                        line   <= 1'b1;
                        state  <= POLL;
                        ret    <= SETADDR;
                        LCD_RS <= 1'b0;
                        LCD_RW <= 1'b1;
                    end else begin
                        state <= DONE;
                        oDone <= 1'b1;
                        oBusy <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
